// File: rtl/yildiz_sys_bus_if.sv
// CPU-side request/ready bus of the Yildiz memory/I/O subsystem.
// The CPU drives the request fields; the subsystem returns ready and read data.
interface yildiz_sys_bus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  cpu_req;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready
  );
endinterface

// File: rtl/yildiz_sys_bus.sv
// Yildiz memory/I/O subsystem: request/ready CPU handshake with wait states,
// internal synchronous RAM and a four-address I/O window (INPR/OUTPR/status).
module yildiz_sys_bus #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int IO_WIDTH    = 8,
  parameter int WAIT_STATES = 1,
  parameter int IO_BASE     = 2**ADDR_WIDTH - 4
) (
  input  logic                clk,
  input  logic                rst,
  yildiz_sys_bus_if.slave     bus,
  input  logic [IO_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IO_WIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                irq
);

  localparam int                    AW1       = ADDR_WIDTH + 1;
  localparam logic [3:0]            WS_LOAD   = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH:0]   IO_LO     = AW1'(IO_BASE);
  localparam logic [ADDR_WIDTH:0]   IO_HI     = AW1'(IO_BASE + 3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [3:0]            cnt_r, cnt_s;
  logic                  latch_s, commit_s;
  logic                  write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  io_hit_s;
  logic [1:0]            io_off_s;
  logic [DATA_WIDTH-1:0] io_rd_s;
  logic [DATA_WIDTH-1:0] ram_q_r, io_q_r, rdata_r;
  logic                  use_ram_r, ready_r;
  logic                  fgi_r, out_valid_r, ien_in_r, ien_out_r, irq_r;
  logic [IO_WIDTH-1:0]   inpr_r, out_data_r;
  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Address decode of the latched transaction into RAM or I/O window
  always_comb begin
    io_hit_s = ({1'b0, addr_r} >= IO_LO) && ({1'b0, addr_r} <= IO_HI);
    io_off_s = addr_r[1:0] - IO_BASE_A[1:0];
  end

  // I/O window read mux
  always_comb begin
    io_rd_s = '0;
    case (io_off_s)
      2'd0:    io_rd_s[IO_WIDTH-1:0] = inpr_r;
      2'd1:    io_rd_s[IO_WIDTH-1:0] = out_data_r;
      2'd2:    io_rd_s[3:0] = {ien_out_r, ien_in_r, ~out_valid_r, fgi_r};
      default: io_rd_s = '0;
    endcase
  end

  // Transaction FSM next-state logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    latch_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req) begin
          latch_s = 1'b1;
          cnt_s   = WS_LOAD;
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else if (write_r && io_hit_s && (io_off_s == 2'd1) && out_valid_r) begin
          // OUTPR still holds an unsent byte: hold the write until it drains
          state_s = ACCESS;
        end else begin
          commit_s = 1'b1;
          state_s  = RESP;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state, request latches and the registered CPU response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      write_r   <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      io_q_r    <= '0;
      use_ram_r <= 1'b0;
      ready_r   <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_r == RESP);
      if (latch_s) begin
        write_r <= bus.cpu_write;
        addr_r  <= bus.cpu_addr;
        wdata_r <= bus.cpu_wdata;
      end
      if (commit_s) begin
        io_q_r    <= write_r ? '0 : io_rd_s;
        use_ram_r <= ~write_r & ~io_hit_s;
      end
      if (state_r == RESP) begin
        rdata_r <= use_ram_r ? ram_q_r : io_q_r;
      end
    end
  end

  // Synchronous RAM; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (commit_s && write_r && !io_hit_s && !rst) begin
      mem[addr_r] <= wdata_r;
    end
    ram_q_r <= mem[addr_r];
  end

  // I/O registers, external handshakes and the interrupt request
  always_ff @(posedge clk) begin
    if (rst) begin
      fgi_r       <= 1'b0;
      inpr_r      <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      ien_in_r    <= 1'b0;
      ien_out_r   <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (commit_s && write_r && io_hit_s) begin
        case (io_off_s)
          2'd1: begin
            out_data_r  <= wdata_r[IO_WIDTH-1:0];
            out_valid_r <= 1'b1;
          end
          2'd2: begin
            ien_in_r  <= wdata_r[2];
            ien_out_r <= wdata_r[3];
          end
          default: ;
        endcase
      end
      if (commit_s && !write_r && io_hit_s && (io_off_s == 2'd0)) begin
        fgi_r <= 1'b0;
      end
      // in_ready is ~fgi_r, so an accept never coincides with the clear above
      if (in_valid && !fgi_r) begin
        inpr_r <= in_data;
        fgi_r  <= 1'b1;
      end
      irq_r <= (fgi_r & ien_in_r) | (~out_valid_r & ien_out_r);
    end
  end

  assign bus.cpu_ready = ready_r;
  assign bus.cpu_rdata = rdata_r;
  assign in_ready      = ~fgi_r;
  assign out_data      = out_data_r;
  assign out_valid     = out_valid_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_yildiz_sys_bus.sv
// Self-checking bench for yildiz_sys_bus: a WAIT_STATES=1 instance checked against
// a transaction-level model, plus a WAIT_STATES=0 instance for the zero-wait case.
module tb_yildiz_sys_bus;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int IW  = 8;
  localparam int IOB = 4092;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  yildiz_sys_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  yildiz_sys_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();

  logic [IW-1:0] in_data1, out_data1, in_data0, out_data0;
  logic in_valid1, in_ready1, out_valid1, out_ready1, irq1;
  logic in_valid0, in_ready0, out_valid0, out_ready0, irq0;

  yildiz_sys_bus #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IO_WIDTH(IW), .WAIT_STATES(1), .IO_BASE(IOB)) dut (
    .clk(clk), .rst(rst), .bus(b1),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .irq(irq1));

  yildiz_sys_bus #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IO_WIDTH(IW), .WAIT_STATES(0), .IO_BASE(IOB)) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .irq(irq0));

  int total = 0;
  int bad = 0;

  // Transaction-level model of the WAIT_STATES=1 instance
  logic [15:0] mem_m [int];
  logic [7:0]  inpr_m, outd_m;
  bit          fgi_m, outv_m, ien_in_m, ien_out_m;

  task automatic m_reset();
    inpr_m = 8'h00; outd_m = 8'h00; fgi_m = 1'b0; outv_m = 1'b0;
    ien_in_m = 1'b0; ien_out_m = 1'b0;
  endtask

  task automatic m_access(input bit wr, input logic [11:0] a, input logic [15:0] d, output logic [15:0] exp);
    int off;
    exp = 16'h0000;
    if (int'(a) < IOB) begin
      if (wr) mem_m[int'(a)] = d;
      else exp = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 16'h0000;
    end else begin
      off = int'(a) - IOB;
      if (wr) begin
        if (off == 1) begin outd_m = d[7:0]; outv_m = 1'b1; end
        else if (off == 2) begin ien_in_m = d[2]; ien_out_m = d[3]; end
      end else begin
        if (off == 0) begin exp = {8'h00, inpr_m}; fgi_m = 1'b0; end
        else if (off == 1) exp = {8'h00, outd_m};
        else if (off == 2) exp = {12'h000, ien_out_m, ien_in_m, ~outv_m, fgi_m};
      end
    end
  endtask

  function automatic bit m_irq();
    return (fgi_m & ien_in_m) | (~outv_m & ien_out_m);
  endfunction

  task automatic issue(input bit sel, input bit wr, input logic [11:0] a, input logic [15:0] d);
    if (sel) begin
      b0.cpu_req = 1'b1; b0.cpu_write = wr; b0.cpu_addr = a; b0.cpu_wdata = d;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_write = wr; b1.cpu_addr = a; b1.cpu_wdata = d;
    end
    @(posedge clk); #1;
    b0.cpu_req = 1'b0; b1.cpu_req = 1'b0;
  endtask

  task automatic wait_ready(input bit sel, output int lat, output logic [15:0] rd);
    lat = -1; rd = 16'h0000;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if ((sel ? b0.cpu_ready : b1.cpu_ready) === 1'b1) begin
        lat = i;
        rd = sel ? b0.cpu_rdata : b1.cpu_rdata;
        break;
      end
    end
  endtask

  task automatic xfer(input bit sel, input bit wr, input logic [11:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output int lat);
    issue(sel, wr, a, d);
    wait_ready(sel, lat, rd);
  endtask

  task automatic do1(input bit wr, input logic [11:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output int lat, output logic [15:0] exp);
    m_access(wr, a, d, exp);
    xfer(1'b0, wr, a, d, rd, lat);
  endtask

  task automatic test_reset();
    total++; if (b1.cpu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", b1.cpu_ready); end
    total++; if (b1.cpu_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got %h want 0000", b1.cpu_rdata); end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
    total++; if (out_data1 !== 8'h00) begin bad++; $display("FAIL reset_out_data got %h want 00", out_data1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq1); end
  endtask

  task automatic test_ram();
    logic [15:0] rd, exp; int lat;
    do1(1'b1, 12'h005, 16'hBEEF, rd, lat, exp);
    total++; if (lat !== 3) begin bad++; $display("FAIL ram_wr_latency got %0d want 3", lat); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL ram_wr_rdata got %h want 0000", rd); end
    do1(1'b0, 12'h005, 16'h0000, rd, lat, exp);
    total++; if (lat !== 3) begin bad++; $display("FAIL ram_rd_latency got %0d want 3", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ram_rd_data got %h want BEEF", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, exp, d; logic [11:0] a; int lat; int addrs[$];
    for (int i = 0; i < 24; i++) begin
      if (i < 2 || addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = (i == 0) ? 12'h000 : (i == 1) ? 12'(IOB - 1) : 12'($urandom_range(0, IOB - 1));
        d = 16'($urandom);
        addrs.push_back(int'(a));
        do1(1'b1, a, d, rd, lat, exp);
      end else begin
        a = 12'(addrs[$urandom_range(0, addrs.size() - 1)]);
        do1(1'b0, a, 16'h0000, rd, lat, exp);
      end
      total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency[%0d] got %0d want 3", i, lat); end
      total++; if (rd !== exp) begin bad++; $display("FAIL b2b_rdata[%0d] addr %h got %h want %h", i, a, rd, exp); end
    end
  endtask

  task automatic test_input();
    logic [15:0] rd, exp; logic [7:0] bya, byb; int lat;
    in_data1 = 8'h5A; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0; inpr_m = 8'h5A; fgi_m = 1'b1;
    total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL in_ready_drop got %b want 0", in_ready1); end
    do1(1'b0, 12'(IOB + 2), 16'h0000, rd, lat, exp);
    total++; if (rd !== exp || rd[3:0] !== 4'b0011) begin bad++; $display("FAIL status_fgi got %h want %h", rd, exp); end
    do1(1'b0, 12'(IOB), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h005A) begin bad++; $display("FAIL inpr_read got %h want 005A", rd); end
    do1(1'b0, 12'(IOB + 2), 16'h0000, rd, lat, exp);
    total++; if (rd !== exp) begin bad++; $display("FAIL status_fgi_clear got %h want %h", rd, exp); end
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL in_ready_back got %b want 1", in_ready1); end
    // INPR read while a new byte waits: old byte returned, new byte taken next cycle
    bya = 8'($urandom); byb = ~bya;
    in_data1 = bya; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    inpr_m = bya; fgi_m = 1'b1;
    in_data1 = byb;
    do1(1'b0, 12'(IOB), 16'h0000, rd, lat, exp);
    inpr_m = byb; fgi_m = 1'b1;
    total++; if (rd !== exp) begin bad++; $display("FAIL inpr_race_old got %h want %h", rd, exp); end
    total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL inpr_race_accept got %b want 0", in_ready1); end
    in_valid1 = 1'b0;
    do1(1'b0, 12'(IOB), 16'h0000, rd, lat, exp);
    total++; if (rd !== exp) begin bad++; $display("FAIL inpr_race_new got %h want %h", rd, exp); end
  endtask

  task automatic test_output();
    logic [15:0] rd, exp; int lat; bit seen;
    out_ready1 = 1'b0;
    do1(1'b1, 12'(IOB + 1), 16'h0041, rd, lat, exp);
    total++; if (lat !== 3) begin bad++; $display("FAIL outpr_latency got %0d want 3", lat); end
    total++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h41) begin bad++; $display("FAIL outpr_first got %b/%h want 1/41", out_valid1, out_data1); end
    do1(1'b0, 12'(IOB + 2), 16'h0000, rd, lat, exp);
    total++; if (rd !== exp) begin bad++; $display("FAIL status_fgo got %h want %h", rd, exp); end
    issue(1'b0, 1'b1, 12'(IOB + 1), 16'h0042);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (b1.cpu_ready === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL stall_no_ready got %b want 0", seen); end
    total++; if (out_data1 !== 8'h41) begin bad++; $display("FAIL stall_hold got %h want 41", out_data1); end
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready1 = 1'b0;
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL stall_drain got %b want 0", out_valid1); end
    wait_ready(1'b0, lat, rd);
    m_access(1'b1, 12'(IOB + 1), 16'h0042, exp);
    total++; if (lat !== 2) begin bad++; $display("FAIL stall_commit_latency got %0d want 2", lat); end
    total++; if (out_valid1 !== 1'b1 || out_data1 !== outd_m) begin bad++; $display("FAIL outpr_second got %b/%h want 1/%h", out_valid1, out_data1, outd_m); end
    do1(1'b0, 12'(IOB + 1), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h0042) begin bad++; $display("FAIL outpr_readback got %h want 0042", rd); end
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready1 = 1'b0; outv_m = 1'b0;
    total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL outpr_sent got %b want 0", out_valid1); end
  endtask

  task automatic test_irq();
    logic [15:0] rd, exp; int lat;
    do1(1'b1, 12'(IOB + 2), 16'h0004, rd, lat, exp);
    total++; if (irq1 !== m_irq()) begin bad++; $display("FAIL irq_idle got %b want %b", irq1, m_irq()); end
    in_data1 = 8'h11; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0; inpr_m = 8'h11; fgi_m = 1'b1;
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_early got %b want 0", irq1); end
    @(posedge clk); @(negedge clk);
    total++; if (irq1 !== m_irq()) begin bad++; $display("FAIL irq_rise got %b want %b", irq1, m_irq()); end
    do1(1'b0, 12'(IOB), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h0011) begin bad++; $display("FAIL irq_inpr got %h want 0011", rd); end
    total++; if (irq1 !== m_irq()) begin bad++; $display("FAIL irq_drop got %b want %b", irq1, m_irq()); end
    do1(1'b1, 12'(IOB + 2), 16'h0008, rd, lat, exp);
    total++; if (irq1 !== m_irq()) begin bad++; $display("FAIL irq_fgo got %b want %b", irq1, m_irq()); end
    do1(1'b0, 12'(IOB + 2), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h000A) begin bad++; $display("FAIL status_ien got %h want 000A", rd); end
    do1(1'b1, 12'(IOB + 3), 16'hFFFF, rd, lat, exp);
    do1(1'b0, 12'(IOB + 3), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL offset3 got %h want 0000", rd); end
    do1(1'b1, 12'(IOB + 2), 16'h0000, rd, lat, exp);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_off got %b want 0", irq1); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd, exp, d0; int lat; bit seen;
    d0 = 16'($urandom);
    do1(1'b1, 12'h010, d0, rd, lat, exp);
    do1(1'b1, 12'(IOB + 2), 16'h000C, rd, lat, exp);
    do1(1'b1, 12'(IOB + 1), 16'h0077, rd, lat, exp);
    in_data1 = 8'h33; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    issue(1'b0, 1'b1, 12'h010, 16'h1234);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    m_reset();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (b1.cpu_ready === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_ready got %b want 0", seen); end
    total++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin bad++; $display("FAIL rstmid_flags got %b/%b want 1/0", in_ready1, out_valid1); end
    total++; if (out_data1 !== 8'h00 || irq1 !== 1'b0) begin bad++; $display("FAIL rstmid_out got %h/%b want 00/0", out_data1, irq1); end
    do1(1'b0, 12'h010, 16'h0000, rd, lat, exp);
    total++; if (rd !== d0) begin bad++; $display("FAIL rstmid_mem got %h want %h", rd, d0); end
    do1(1'b0, 12'(IOB), 16'h0000, rd, lat, exp);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rstmid_inpr got %h want 0000", rd); end
  endtask

  task automatic test_ws0();
    logic [15:0] rd; int lat; logic [15:0] m0 [int]; logic [11:0] a;
    xfer(1'b1, 1'b1, 12'hFFB, 16'h7777, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL ws0_wr_latency got %0d want 2", lat); end
    xfer(1'b1, 1'b1, 12'hFFC, 16'h7777, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL ws0_io_latency got %0d want 2", lat); end
    xfer(1'b1, 1'b0, 12'hFFB, 16'h0000, rd, lat);
    total++; if (rd !== 16'h7777 || lat !== 2) begin bad++; $display("FAIL ws0_ram_top got %h/%0d want 7777/2", rd, lat); end
    xfer(1'b1, 1'b0, 12'hFFC, 16'h0000, rd, lat);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL ws0_inpr got %h want 0000", rd); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL ws0_in_ready got %b want 1", in_ready0); end
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom_range(0, IOB - 2));
      m0[int'(a)] = 16'($urandom);
      xfer(1'b1, 1'b1, a, m0[int'(a)], rd, lat);
      xfer(1'b1, 1'b0, a, 16'h0000, rd, lat);
      total++; if (rd !== m0[int'(a)] || lat !== 2) begin bad++; $display("FAIL ws0_rand[%0d] got %h/%0d want %h/2", i, rd, lat, m0[int'(a)]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    b1.cpu_req = 1'b0; b1.cpu_write = 1'b0; b1.cpu_addr = 12'h000; b1.cpu_wdata = 16'h0000;
    b0.cpu_req = 1'b0; b0.cpu_write = 1'b0; b0.cpu_addr = 12'h000; b0.cpu_wdata = 16'h0000;
    in_data1 = 8'h00; in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_data0 = 8'h00; in_valid0 = 1'b0; out_ready0 = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_ram();
    test_back_to_back();
    test_input();
    test_output();
    test_irq();
    test_reset_mid();
    test_ws0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
